// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, address width
// and the legality/alignment predicate used when a request is accepted.
package lsu_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // funct3[1:0] encodes the access size for every legal code, so alignment keys off it.
  function automatic logic req_ok(input logic store, input logic [2:0] f3, input logic [1:0] lo);
    logic legal;
    logic aligned;
    if (store) legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else       legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                       (f3 == F3_LBU) || (f3 == F3_LHU);
    case (f3[1:0])
      2'd1:    aligned = ~lo[0];
      2'd2:    aligned = (lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data extraction: picks the byte/halfword lane from the memory
// word and sign- or zero-extends it; zero latency, no flow control.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data_o = word_i;
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request per 3 cycles (accept, ACCESS, RESP); errors respond after 1 cycle.
// req_ready is high only in IDLE; requests presented while busy are ignored, not queued.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] daddr,
  output logic [31:0]       dwdata,
  output logic [3:0]        we,
  input  logic [31:0]       drdata
);

  state_e            state_q, state_d;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       ld_res;
  logic              accept;
  logic              ok;
  logic              in_access;

  assign accept = req_valid && req_ready;
  assign ok     = req_ok(req_store, req_funct3, req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ok ? ACCESS : RESP;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align u_align (
    .funct3_i (f3_q),
    .lane_i   (addr_q[1:0]),
    .word_i   (drdata),
    .data_o   (ld_res)
  );

  // Response registers are loaded for exactly one cycle so they read 0 outside RESP.
  assign err_d   = accept && !ok;
  assign rdata_d = (state_q == ACCESS && !store_q) ? ld_res : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory side is gated by reset directly so a reset mid-ACCESS kills the write that cycle.
  always_comb begin
    in_access  = (state_q == ACCESS) && !reset;
    req_ready  = (state_q == IDLE) && !reset;
    resp_valid = (state_q == RESP) && !reset;
    resp_err   = err_q && !reset;
    resp_rdata = rdata_q;
    daddr      = '0;
    dwdata     = '0;
    we         = '0;
    if (in_access) begin
      daddr = addr_q;
      if (store_q) begin
        case (f3_q[1:0])
          2'd0: begin
            we     = 4'b0001 << addr_q[1:0];
            dwdata = {4{wdata_q[7:0]}};
          end
          2'd1: begin
            we     = addr_q[1] ? 4'b1100 : 4'b0011;
            dwdata = {2{wdata_q[15:0]}};
          end
          2'd2: begin
            we     = 4'b1111;
            dwdata = wdata_q;
          end
          default: begin
            we     = 4'b0000;
            dwdata = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, reset/back-to-back sequences, random traffic
// against a byte-array memory model, and a standalone check of lsu_load_align.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .daddr      (daddr),
    .dwdata     (dwdata),
    .we         (we),
    .drdata     (drdata)
  );

  logic [2:0]  la_f3;
  logic [1:0]  la_lane;
  logic [31:0] la_word;
  logic [31:0] la_res;

  lsu_load_align u_la (
    .funct3_i (la_f3),
    .lane_i   (la_lane),
    .word_i   (la_word),
    .data_o   (la_res)
  );

  // Memory attached to the DUT: combinational read, byte-lane write at the clock edge.
  logic [31:0] dmem [64];
  assign drdata = dmem[daddr[7:2]];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) dmem[daddr[7:2]][8*i +: 8] <= dwdata[8*i +: 8];
  end

  // Reference memory, kept as individual bytes.
  logic [7:0] ref_mem [256];

  int mon_en = 0;
  int mon_cyc = 0;
  int acc_n = 0;
  int resp_n = 0;
  int resp_cyc [8];
  int resp_total = 0;

  always @(negedge clk) begin
    if (resp_valid) resp_total++;
    if (mon_en != 0) begin
      mon_cyc++;
      if (req_valid && req_ready) acc_n++;
      if (resp_valid) begin
        if (resp_n < 8) resp_cyc[resp_n] = mon_cyc;
        resp_n++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic ref_access(input logic store, input logic [2:0] f3, input logic [7:0] addr,
                            input logic [31:0] wdata, output logic err, output logic [3:0] ewe,
                            output logic [31:0] edw, output logic [31:0] erd);
    int size;
    int lo;
    logic legal;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    lo    = int'(addr[1:0]);
    legal = store ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !(legal && ((int'(addr) % size) == 0));
    ewe = '0; edw = '0; erd = '0;
    if (!err && store) begin
      for (int i = 0; i < 4; i++) begin
        edw[8*i +: 8] = wdata[8*(i % size) +: 8];
        ewe[i] = (i >= lo) && (i < lo + size);
      end
      for (int k = 0; k < size; k++) ref_mem[8'(addr + k)] = wdata[8*k +: 8];
    end else if (!err) begin
      v = '0;
      for (int k = 0; k < size; k++) v = v | (32'(ref_mem[8'(addr + k)]) << (8*k));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (32'd1 << (8*size));
      erd = v;
    end
  endtask

  task automatic do_req(input string nm, input logic store, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic eerr,
                        input logic [3:0] ewe, input logic [31:0] edw, input logic [31:0] erd);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
      return;
    end
    req_store = store; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (eerr) begin
      chk({nm, "_err_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, "_err_flag"},  32'(resp_err),   32'd1);
      chk({nm, "_err_rdata"}, resp_rdata,      32'd0);
      chk({nm, "_err_we"},    32'(we),         32'd0);
      @(posedge clk); #1;
      chk({nm, "_err_after"}, 32'(resp_valid), 32'd0);
    end else begin
      chk({nm, "_acc_valid"}, 32'(resp_valid), 32'd0);
      chk({nm, "_acc_daddr"}, daddr,           addr);
      chk({nm, "_acc_we"},    32'(we),         32'(ewe));
      chk({nm, "_acc_dwdata"}, dwdata,         edw);
      @(posedge clk); #1;
      chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, "_resp_err"},   32'(resp_err),   32'd0);
      chk({nm, "_resp_rdata"}, resp_rdata,      erd);
      chk({nm, "_resp_we"},    32'(we),         32'd0);
      @(posedge clk); #1;
      chk({nm, "_idle_valid"}, 32'(resp_valid), 32'd0);
      chk({nm, "_idle_rdata"}, resp_rdata,      32'd0);
    end
  endtask

  function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * int'(lane))) & 32'h0000_00FF;
    h = (word >> (16 * int'(lane[1]))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return word;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  we;
    logic [31:0] dwd;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    logic        e_err;
    logic [3:0]  e_we;
    logic [31:0] e_dw, e_rd, w;
    logic [2:0]  f3v;
    logic [7:0]  a8;
    logic        st;
    logic [2:0]  la_codes [5];
    int          r0;

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (i == 4) w = 32'h8765_4321;
      if (i == 8) w = 32'h1122_3344;
      dmem[i] = w;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
    end

    tbl[0]  = '{1'b0, 3'd0, 32'h13, 32'h0,         1'b0, 4'b0000, 32'h0,         32'hFFFF_FF87};
    tbl[1]  = '{1'b0, 3'd4, 32'h13, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_0087};
    tbl[2]  = '{1'b0, 3'd1, 32'h12, 32'h0,         1'b0, 4'b0000, 32'h0,         32'hFFFF_8765};
    tbl[3]  = '{1'b0, 3'd5, 32'h10, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0000_4321};
    tbl[4]  = '{1'b0, 3'd2, 32'h10, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h8765_4321};
    tbl[5]  = '{1'b1, 3'd0, 32'h11, 32'h1234_56AB, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0};
    tbl[6]  = '{1'b0, 3'd2, 32'h10, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h8765_AB21};
    tbl[7]  = '{1'b1, 3'd1, 32'h11, 32'hCAFE_1234, 1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[8]  = '{1'b0, 3'd2, 32'h12, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[9]  = '{1'b0, 3'd3, 32'h10, 32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 3'd2, 32'h10, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h8765_AB21};

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    la_f3 = '0; la_lane = '0; la_word = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  32'(req_ready),  32'd0);
    chk("rst_valid",  32'(resp_valid), 32'd0);
    chk("rst_err",    32'(resp_err),   32'd0);
    chk("rst_we",     32'(we),         32'd0);
    chk("rst_rdata",  resp_rdata,      32'd0);
    chk("rst_daddr",  daddr,           32'd0);
    chk("rst_dwdata", dwdata,          32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      ref_access(tbl[i].store, tbl[i].f3, tbl[i].addr[7:0], tbl[i].wdata, e_err, e_we, e_dw, e_rd);
      do_req($sformatf("vec%0d", i), tbl[i].store, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
             tbl[i].err, tbl[i].we, tbl[i].dwd, tbl[i].rd);
    end
    chk("mem_0x10_after_errors", dmem[4], 32'h8765_AB21);

    // SW with reset landing in its ACCESS cycle: write suppressed, no response.
    @(posedge clk); #1;
    r0 = resp_total;
    req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstacc_we_before", 32'(we), 32'hF);
    reset = 1'b1;
    #1;
    chk("rstacc_we",     32'(we),        32'd0);
    chk("rstacc_daddr",  daddr,          32'd0);
    chk("rstacc_dwdata", dwdata,         32'd0);
    chk("rstacc_ready",  32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rstacc_valid", 32'(resp_valid), 32'd0);
    chk("rstacc_rdata", resp_rdata,      32'd0);
    reset = 1'b0;
    #1;
    chk("rstacc_ready_release", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rstacc_no_resp", 32'(resp_total), 32'(r0));
    chk("rstacc_mem", dmem[8], 32'h1122_3344);
    ref_access(1'b0, 3'd2, 8'h20, 32'h0, e_err, e_we, e_dw, e_rd);
    do_req("rstacc_lw", 1'b0, 3'd2, 32'h20, 32'h0, e_err, e_we, e_dw, e_rd);

    // Back-to-back: requester holds valid for 9 cycles.
    req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = '0; req_valid = 1'b1;
    mon_en = 1;
    repeat (9) @(posedge clk);
    #1;
    req_valid = 1'b0;
    mon_en = 0;
    chk("b2b_accepts", 32'(acc_n),  32'd3);
    chk("b2b_resps",   32'(resp_n), 32'd3);
    if (resp_n >= 3) begin
      chk("b2b_gap1", 32'(resp_cyc[1] - resp_cyc[0]), 32'd3);
      chk("b2b_gap2", 32'(resp_cyc[2] - resp_cyc[1]), 32'd3);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      st  = 1'($urandom_range(0, 1));
      f3v = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3v = {1'b0, 2'($urandom_range(0, 2))};
      a8  = 8'($urandom_range(0, 255));
      w   = $urandom;
      ref_access(st, f3v, a8, w, e_err, e_we, e_dw, e_rd);
      do_req($sformatf("rnd%0d", i), st, f3v, {24'd0, a8}, w, e_err, e_we, e_dw, e_rd);
    end

    la_codes[0] = 3'd0; la_codes[1] = 3'd1; la_codes[2] = 3'd2; la_codes[3] = 3'd4; la_codes[4] = 3'd5;
    for (int i = 0; i < 24; i++) begin
      la_f3   = la_codes[$urandom_range(0, 4)];
      la_lane = 2'($urandom_range(0, 3));
      la_word = $urandom;
      if (i < 5) begin
        la_f3 = la_codes[i];
        la_lane = 2'd3;
        la_word = 32'h8080_8080;
      end
      #1;
      chk($sformatf("align%0d", i), la_res, ref_extract(la_f3, la_lane, la_word));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
